mu_mac4: RTL

Four-lane multiply-accumulate stage that sits directly upstream of the writeback block. It consumes a stream of data samples, each with four per-lane coefficients. Each lane accumulates K products and then presents four 18-bit results on MU1..MU4 with a one-cycle web strobe. After each strobe it enforces a hold-off window so writeback can drain all four words to RAM before the next strobe.

---
 rtl/mu_mac4_if.sv | 32 +++
 rtl/mu_mac4.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mu_mac4_if.sv
// Stream-side bundle of the four-lane MAC stage: sample/coefficient input,
// abort, and the result set with its web strobe.
interface mu_mac4_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 7,
    parameter int OUT_W  = 18
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic [COEF_W-1:0] coef1;
    logic [COEF_W-1:0] coef2;
    logic [COEF_W-1:0] coef3;
    logic [COEF_W-1:0] coef4;
    logic              abort;
    logic              web;
    logic [OUT_W-1:0]  MU1;
    logic [OUT_W-1:0]  MU2;
    logic [OUT_W-1:0]  MU3;
    logic [OUT_W-1:0]  MU4;
    logic              busy;

    modport master (
        output in_valid, data_in, coef1, coef2, coef3, coef4, abort,
        input  in_ready, web, MU1, MU2, MU3, MU4, busy
    );

    modport slave (
        input  in_valid, data_in, coef1, coef2, coef3, coef4, abort,
        output in_ready, web, MU1, MU2, MU3, MU4, busy
    );
endinterface

// File: rtl/mu_mac4.sv
// Four-lane saturating multiply-accumulate: K products per lane, then a one-cycle
// web strobe with MU1..MU4, followed by a HOLD_CYC-cycle drain window.
module mu_mac4 #(
    parameter int K        = 4,
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 7,
    parameter int OUT_W    = 18,
    parameter int HOLD_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    mu_mac4_if.slave   bus
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int CNT_W  = (K < 2) ? 1 : $clog2(K);
    localparam int HOLD_W = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [HOLD_W-1:0] hold_q;
    logic              web_q;
    logic              in_ready;
    logic              busy;
    logic              abort_eff;
    logic              accept;
    logic              last_acc;
    logic [COEF_W-1:0] coef [4];

    assign coef[0] = bus.coef1;
    assign coef[1] = bus.coef2;
    assign coef[2] = bus.coef3;
    assign coef[3] = bus.coef4;

    // An abort during HOLD is ignored: the result already issued stands.
    assign abort_eff = bus.abort && (state_q != S_HOLD);
    assign accept    = bus.in_valid && in_ready && !abort_eff;
    assign last_acc  = accept && (cnt_q == CNT_W'(K - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_ACC: begin
                if (abort_eff) begin
                    state_d = S_IDLE;
                end else if (last_acc) begin
                    state_d = S_HOLD;
                end else if (accept) begin
                    state_d = S_ACC;
                end
            end
            S_HOLD: begin
                if (hold_q <= HOLD_W'(1)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // in_ready is a pure function of state, never of in_valid.
    always_comb begin
        in_ready = (state_q != S_HOLD);
        busy     = (state_q != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            hold_q <= '0;
            web_q  <= 1'b0;
        end else begin
            web_q <= last_acc;
            if (state_q == S_HOLD && hold_q != '0) begin
                hold_q <= hold_q - HOLD_W'(1);
            end
            if (abort_eff) begin
                cnt_q <= '0;
            end else if (last_acc) begin
                cnt_q  <= '0;
                hold_q <= HOLD_W'(HOLD_CYC);
            end else if (accept) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [PROD_W-1:0] prod;
            logic [OUT_W:0]    sum_full;
            logic [OUT_W-1:0]  sum_sat;
            logic [OUT_W-1:0]  acc_q;
            logic [OUT_W-1:0]  mu_q;

            assign prod     = PROD_W'(bus.data_in) * PROD_W'(coef[gi]);
            assign sum_full = {1'b0, acc_q} + (OUT_W + 1)'(prod);
            assign sum_sat  = sum_full[OUT_W] ? '1 : sum_full[OUT_W-1:0];

            // acc_q is zero whenever the stage is idle, so the first accept
            // simply loads the product.
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q <= '0;
                    mu_q  <= '0;
                end else if (abort_eff) begin
                    acc_q <= '0;
                end else if (last_acc) begin
                    acc_q <= '0;
                    mu_q  <= sum_sat;
                end else if (accept) begin
                    acc_q <= sum_sat;
                end
            end
        end
    endgenerate

    assign bus.in_ready = in_ready;
    assign bus.busy     = busy;
    assign bus.web      = web_q;
    assign bus.MU1      = g_lane[0].mu_q;
    assign bus.MU2      = g_lane[1].mu_q;
    assign bus.MU3      = g_lane[2].mu_q;
    assign bus.MU4      = g_lane[3].mu_q;
endmodule
